// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential unsigned restoring divider, one quotient bit per clock
//
// Purpose : divides a DW-bit dividend by a VW-bit divisor, returning a DW-bit
//           quotient and VW-bit remainder via a start/busy/done handshake.
// Config  : DIV_ZERO_CHECK_EN - when defined, a zero divisor bypasses the
//           iteration and finishes in one cycle with div_zero_o raised;
//           when undefined, div_zero_o is tied low.
// Ports   : clk_i        rising-edge clock
//           rst_i        synchronous active-high reset
//           start_i      request pulse, sampled only in IDLE
//           dividend_i   dividend, captured on the accepted start
//           divisor_i    divisor, captured on the accepted start
//           quotient_o   result, held until the next done
//           remainder_o  result, held until the next done
//           busy_o       high while iterating
//           done_o       one-cycle pulse when results update
//           div_zero_o   divide-by-zero flag, updated with done
module seq_div #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic [DW-1:0] quotient_o,
  output logic [VW-1:0] remainder_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          div_zero_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  // dvd_q shifts the dividend out of its MSB while quotient bits enter its
  // LSB, so after DW iterations it holds the quotient.
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dsr_q, dsr_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          done_q, done_d;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          borrow;
  logic          unused_diff_msb;

`ifdef DIV_ZERO_CHECK_EN
  logic          dz_q, dz_d;
  logic          dzo_q, dzo_d;
`endif

  // Only a zero divisor can make the non-negative difference exceed VW bits;
  // in that case the low VW bits are exactly the shifted trial value.
  assign unused_diff_msb = diff[VW];

  always_comb begin
    trial   = {rem_q, dvd_q[DW-1]};
    {borrow, diff} = {1'b0, trial} - {2'b00, dsr_q};

    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    done_d  = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
    dzo_d   = dzo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dvd_d   = dividend_i;
          dsr_d   = divisor_i;
          rem_d   = '0;
          cnt_d   = CW'(DW);
          state_d = S_RUN;
`ifdef DIV_ZERO_CHECK_EN
          dz_d    = 1'b0;
          if (divisor_i == '0) begin
            dvd_d   = '1;
            rem_d   = dividend_i[VW-1:0];
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (!borrow) begin
          rem_d = diff[VW-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b1};
        end else begin
          rem_d = trial[VW-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b0};
        end
        if (cnt_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        quot_d  = dvd_q;
        remo_d  = rem_q;
        done_d  = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
        dzo_d   = dz_q;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= 1'b0;
      dzo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= dz_d;
      dzo_q   <= dzo_d;
`endif
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = remo_q;
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = done_q;
`ifdef DIV_ZERO_CHECK_EN
  assign div_zero_o  = dzo_q;
`else
  assign div_zero_o  = 1'b0;
`endif

endmodule
